// File: rtl/sram_write_buffer.sv
// Store buffer between the cache controller and the SRAM controller: queues stores, drains them
// in the background, forwards loads from the youngest matching entry and reads SRAM on a miss.
module sram_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        sram_write_en,
  output logic        sram_read_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_read_data,
  input  logic        sram_ready
);

  typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

  state_t             state_q, state_d;
  logic [31:0]        ent_addr_q [DEPTH];
  logic [31:0]        ent_data_q [DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [PTR_W:0]     count_q, count_d;
  logic               wen_q, wen_d;
  logic               ren_q, ren_d;
  logic [31:0]        saddr_q, saddr_d;
  logic [31:0]        swdata_q, swdata_d;
  logic [31:0]        rdata_q;

  logic               full;
  logic               push;
  logic               pop;
  logic               read_done;
  logic               hit;
  logic [31:0]        hit_data;
  logic [PTR_W-1:0]   idx;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign push      = wr_req & ~full;
  assign pop       = (state_q == DRAIN) & sram_ready;
  assign read_done = (state_q == READ) & sram_ready;

  // Walk from head to tail so a later (younger) match overrides an older one.
  always_comb begin
    hit      = 1'b0;
    hit_data = 32'h0;
    idx      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) && (ent_addr_q[idx] == addr)) begin
        hit      = 1'b1;
        hit_data = ent_data_q[idx];
      end
    end
  end

  always_comb begin
    ready = 1'b1;
    if (wr_req) begin
      ready = ~full;
    end else if (rd_req) begin
      ready = hit | read_done;
    end
  end

  always_comb begin
    rdata = rdata_q;
    if (rd_req && hit) begin
      rdata = hit_data;
    end else if (read_done) begin
      rdata = sram_read_data;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    wen_d    = wen_q;
    ren_d    = ren_q;
    saddr_d  = saddr_q;
    swdata_d = swdata_q;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d  = DRAIN;
          wen_d    = 1'b1;
          saddr_d  = ent_addr_q[head_q];
          swdata_d = ent_data_q[head_q];
        end else if (push) begin
          // Empty buffer: the store being accepted now becomes the head, start it right away.
          state_d  = DRAIN;
          wen_d    = 1'b1;
          saddr_d  = addr;
          swdata_d = wdata;
        end else if (rd_req && !hit) begin
          state_d = READ;
          ren_d   = 1'b1;
          saddr_d = addr;
        end
      end
      DRAIN: begin
        if (sram_ready) begin
          state_d = IDLE;
          wen_d   = 1'b0;
        end
      end
      READ: begin
        if (sram_ready) begin
          state_d = IDLE;
          ren_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      wen_q    <= 1'b0;
      ren_q    <= 1'b0;
      saddr_q  <= 32'h0;
      swdata_q <= 32'h0;
      rdata_q  <= 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= 32'h0;
        ent_data_q[i] <= 32'h0;
      end
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      saddr_q  <= saddr_d;
      swdata_q <= swdata_d;
      if (push) begin
        ent_addr_q[tail_q] <= addr;
        ent_data_q[tail_q] <= wdata;
        tail_q             <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      if (read_done) begin
        rdata_q <= sram_read_data;
      end
    end
  end

  assign sram_write_en = wen_q;
  assign sram_read_en  = ren_q;
  assign sram_addr     = saddr_q;
  assign sram_wdata    = swdata_q;

endmodule

// File: tb/tb_sram_write_buffer.sv
// Self-checking bench for sram_write_buffer: SRAM model with a write scoreboard plus per-scenario tasks.
module tb_sram_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req, rd_req;
  logic [31:0] addr, wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        sram_write_en, sram_read_en;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_read_data;
  logic        sram_ready;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_wr_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_done  = 0;
  int          sram_lat = 4;
  logic        sram_stall = 1'b0;
  logic [31:0] rd_val = 32'h0;
  logic        rd_en_seen = 1'b0;

  sram_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .sram_write_en(sram_write_en), .sram_read_en(sram_read_en),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_read_data(sram_read_data),
    .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sram_read_en) rd_en_seen = 1'b1;

  // SRAM controller model: pulses sram_ready after sram_lat cycles of a held enable.
  initial begin
    int lat_cnt;
    wr_t e;
    lat_cnt = 0;
    sram_ready = 1'b0;
    sram_read_data = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        sram_ready = 1'b0;
        lat_cnt = 0;
      end else if (sram_ready) begin
        sram_ready = 1'b0;
      end else if ((sram_write_en || sram_read_en) && !sram_stall) begin
        lat_cnt++;
        if (lat_cnt >= sram_lat) begin
          lat_cnt = 0;
          sram_ready = 1'b1;
          if (sram_write_en) begin
            n_checks++;
            if (exp_wr_q.size() == 0) begin
              n_fail++;
              $display("FAIL sram_write_unexpected: got addr=%h data=%h, expected no write", sram_addr, sram_wdata);
            end else begin
              e = exp_wr_q.pop_front();
              if (sram_addr !== e.a || sram_wdata !== e.d) begin
                n_fail++;
                $display("FAIL sram_write_order: got addr=%h data=%h, expected addr=%h data=%h", sram_addr, sram_wdata, e.a, e.d);
              end
            end
            wr_done++;
          end else begin
            sram_read_data = rd_val;
          end
        end
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int max, output int waited);
    wr_t e;
    @(negedge clk);
    wr_req = 1'b1; rd_req = 1'b0; addr = a; wdata = d;
    #1;
    waited = 0;
    while (!ready && waited < max) begin
      @(negedge clk); #1;
      waited++;
    end
    if (ready) begin
      e.a = a; e.d = d;
      exp_wr_q.push_back(e);
    end else begin
      n_checks++; n_fail++;
      $display("FAIL store_timeout: ready=%b after %0d cycles, expected 1", ready, waited);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic wait_empty(input int max);
    int k;
    k = 0;
    @(negedge clk); #1;
    while ((dut.count_q != 0 || sram_write_en) && k < max) begin
      @(negedge clk); #1;
      k++;
    end
    n_checks++;
    if (dut.count_q != 0 || sram_write_en || exp_wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: count=%0d wen=%b pending=%0d, expected 0 0 0", dut.count_q, sram_write_en, exp_wr_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_checks += 4;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
      if (sram_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b expected 0", sram_write_en); end
      if (sram_read_en !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %b expected 0", sram_read_en); end
      if (dut.count_q !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", dut.count_q); end
    end
    n_checks += 2;
    if (sram_addr !== 32'h0) begin n_fail++; $display("FAIL reset_saddr: got %h expected 0", sram_addr); end
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
  endtask

  task automatic test_single_store();
    int w, k;
    logic held;
    sram_stall = 1'b0; sram_lat = 4;
    do_store(32'h0000_0400, 32'hDEAD_BEEF, 20, w);
    n_checks++;
    if (w != 0) begin n_fail++; $display("FAIL single_ready_same_cycle: waited %0d expected 0", w); end
    go_idle(); #1;
    n_checks += 3;
    if (sram_write_en !== 1'b1) begin n_fail++; $display("FAIL single_wen: got %b expected 1", sram_write_en); end
    if (sram_addr !== 32'h400) begin n_fail++; $display("FAIL single_saddr: got %h expected 400", sram_addr); end
    if (sram_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_swdata: got %h expected deadbeef", sram_wdata); end
    held = 1'b1; k = 0;
    while (!sram_ready && k < 20) begin
      if (!sram_write_en || sram_addr !== 32'h400 || sram_wdata !== 32'hDEAD_BEEF) held = 1'b0;
      @(negedge clk); #1;
      k++;
    end
    n_checks += 2;
    if (!held) begin n_fail++; $display("FAIL single_hold: got held=0 expected 1"); end
    if (k != 3) begin n_fail++; $display("FAIL single_latency: pulse after %0d more cycles, expected 3", k); end
    wait_empty(50);
  endtask

  task automatic test_back_to_back();
    int w, base, k;
    sram_stall = 1'b1; sram_lat = 2;
    for (int i = 1; i <= 4; i++) begin
      do_store(32'h0000_1000 + 32'(i), 32'h5000_0000 + 32'(i), 10, w);
      n_checks++;
      if (w != 0) begin n_fail++; $display("FAIL b2b_accept_%0d: waited %0d expected 0", i, w); end
    end
    @(negedge clk);
    addr = 32'h0000_1005; wdata = 32'h5000_0005;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b expected 0", ready); end
      @(negedge clk);
    end
    base = wr_done;
    sram_stall = 1'b0;
    #1; k = 0;
    while (!ready && k < 30) begin @(negedge clk); #1; k++; end
    n_checks += 2;
    if (!ready) begin n_fail++; $display("FAIL b2b_fifth_accept: got ready=%b expected 1", ready); end
    if (wr_done != base + 1) begin n_fail++; $display("FAIL b2b_ready_after_pop: writes done %0d expected %0d", wr_done - base, 1); end
    if (ready) exp_wr_q.push_back('{32'h0000_1005, 32'h5000_0005});
    go_idle();
    wait_empty(100);
  endtask

  task automatic test_forward();
    int w;
    sram_stall = 1'b1;
    rd_en_seen = 1'b0;
    do_store(32'h100, 32'h11, 10, w);
    do_store(32'h100, 32'h22, 10, w);
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b1; addr = 32'h100;
    #1;
    n_checks += 2;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL fwd_ready: got %b expected 1", ready); end
    if (rdata !== 32'h22) begin n_fail++; $display("FAIL fwd_rdata: got %h expected 22", rdata); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (rd_en_seen) begin n_fail++; $display("FAIL fwd_no_sram_read: read_en seen=1 expected 0"); end
    rd_req = 1'b0;
    sram_stall = 1'b0;
    wait_empty(100);
  endtask

  task automatic test_miss_load();
    int w, k;
    logic early;
    sram_stall = 1'b0; sram_lat = 3; rd_val = 32'hCAFE_F00D;
    do_store(32'h300, 32'h0000_0001, 10, w);
    do_store(32'h304, 32'h0000_0002, 10, w);
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b1; addr = 32'h200;
    #1;
    early = 1'b0; k = 0;
    while (!ready && k < 100) begin
      if (sram_read_en && exp_wr_q.size() != 0) early = 1'b1;
      @(negedge clk); #1;
      k++;
    end
    n_checks += 6;
    if (!ready) begin n_fail++; $display("FAIL miss_ready: got %b expected 1", ready); end
    if (early) begin n_fail++; $display("FAIL miss_order: read issued before writes drained"); end
    if (sram_ready !== 1'b1) begin n_fail++; $display("FAIL miss_ready_on_pulse: sram_ready=%b expected 1", sram_ready); end
    if (rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL miss_rdata: got %h expected cafef00d", rdata); end
    if (sram_read_en !== 1'b1 || sram_addr !== 32'h200) begin
      n_fail++; $display("FAIL miss_sram_req: ren=%b addr=%h expected 1 200", sram_read_en, sram_addr);
    end
    if (exp_wr_q.size() != 0) begin n_fail++; $display("FAIL miss_writes_first: %0d pending expected 0", exp_wr_q.size()); end
    go_idle();
    #1;
    n_checks++;
    if (sram_read_en !== 1'b0) begin n_fail++; $display("FAIL miss_ren_drop: got %b expected 0", sram_read_en); end
  endtask

  task automatic test_wrap();
    int w;
    sram_stall = 1'b0; sram_lat = 2;
    for (int i = 0; i < 9; i++) begin
      do_store(32'h2000 + 32'(i * 4), 32'hA000 + 32'(i), 20, w);
      if (i % 3 == 2) begin
        go_idle();
        wait_empty(100);
      end
    end
    sram_stall = 1'b1;
    do_store(32'h2000, 32'hA009, 20, w);
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b1; addr = 32'h2000;
    #1;
    n_checks += 2;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL wrap_fwd_ready: got %b expected 1", ready); end
    if (rdata !== 32'hA009) begin n_fail++; $display("FAIL wrap_fwd_rdata: got %h expected a009", rdata); end
    go_idle();
    sram_stall = 1'b0;
    wait_empty(100);
  endtask

  task automatic test_reset_mid_drain();
    int w;
    sram_stall = 1'b1;
    do_store(32'h500, 32'h55, 10, w);
    do_store(32'h504, 32'h66, 10, w);
    go_idle(); #1;
    n_checks++;
    if (sram_write_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_draining: wen=%b expected 1", sram_write_en); end
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks += 4;
    if (dut.count_q !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", dut.count_q); end
    if (sram_write_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_wen: got %b expected 0", sram_write_en); end
    if (sram_read_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_ren: got %b expected 0", sram_read_en); end
    if (sram_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_saddr: got %h expected 0", sram_addr); end
    exp_wr_q.delete();
    rst = 1'b0;
    sram_stall = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    n_checks++;
    if (sram_write_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_discarded: wen=%b expected 0", sram_write_en); end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_back_to_back();
    test_forward();
    test_miss_load();
    test_wrap();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
